// File: rtl/druaga_rom_pkg.sv
// druaga_rom_pkg
//   Shared types and constants for the Druaga ROM download loader.
//   - state_e  : loader sequencing states
//   - region_t : one ROM region, base byte address and size in bytes
//   - REGION   : the core's region map (main, sub, chr, obj), laid out back to back
//   - CSUM_EXP : expected 8-bit additive sum of a good image; it is only
//                consulted when DRUAGA_ROM_CSUM_EN is defined
package druaga_rom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef struct packed {
        logic [24:0] base;
        logic [16:0] size;
    } region_t;

    localparam int unsigned REGION_CNT = 4;

    localparam region_t REGION [REGION_CNT] = '{
        '{base: 25'h00000, size: 17'h08000},   // main cpu
        '{base: 25'h08000, size: 17'h02000},   // sub cpu
        '{base: 25'h0A000, size: 17'h01000},   // chr
        '{base: 25'h0B000, size: 17'h08000}    // obj
    };

    localparam logic [7:0] CSUM_EXP = 8'hA5;

endpackage

// File: rtl/druaga_rom_decode.sv
// druaga_rom_decode
//   Combinational match of a linear download address against one ROM region.
//   Ports:
//     addr_i : linear download byte address
//     hit_o  : BASE <= addr_i < BASE + SIZE
//     off_o  : region-relative address, low 16 bits of addr_i - BASE
module druaga_rom_decode #(
    parameter logic [24:0] BASE = 25'h0,
    parameter logic [16:0] SIZE = 17'h1
) (
    input  logic [24:0] addr_i,
    output logic        hit_o,
    output logic [15:0] off_o
);

    // One extra bit catches the borrow, so addr < BASE shows up as diff[25].
    logic [25:0] diff;

    assign diff  = {1'b0, addr_i} - {1'b0, BASE};
    assign hit_o = ~diff[25] && (diff[24:0] < {8'b0, SIZE});
    assign off_o = diff[15:0];

endmodule

// File: rtl/druaga_rom_loader.sv
// druaga_rom_loader
//   Routes the HPS ROM download stream into the game core's per-region ROM
//   write ports, counts the bytes it accepts, keeps the core in reset while
//   loading and for RST_HOLD cycles afterwards, and reports done or error.
//   Ports (all on MCLK):
//     MCLK, RESET_N       : clock, asynchronous active-low reset
//     DL_ACT/DL_WR        : download active level, one-cycle byte strobe
//     DL_ADDR/DL_DATA     : linear byte address and data
//     ROM_WE/ROM_AD/ROM_DT: one-hot region strobe, region offset, data. These
//                           follow the accepted write by one cycle.
//     CORE_RST            : active-high reset to the game core
//     DL_DONE/DL_ERR      : full download finished / short or bad download
//   Build option DRUAGA_ROM_CSUM_EN adds an additive byte sum. The sum must
//   equal CSUM_EXP for the download to pass, and it is brought out on port CSUM.
//
//   state  | meaning
//   IDLE   | after reset, core held, waiting for DL_ACT
//   LOAD   | download running, writes decoded and counted
//   SETTLE | download good, core held for RST_HOLD cycles
//   RUN    | core released, DL_DONE set
//   HALT   | bad download, core held, DL_ERR set
module druaga_rom_loader
    import druaga_rom_pkg::*;
#(
    parameter int unsigned NREG        = 4,
    parameter int unsigned RST_HOLD    = 256,
    parameter logic [19:0] TOTAL_BYTES = 20'h13000
) (
    input  logic            MCLK,
    input  logic            RESET_N,
    input  logic            DL_ACT,
    input  logic            DL_WR,
    input  logic [24:0]     DL_ADDR,
    input  logic [7:0]      DL_DATA,
    output logic [NREG-1:0] ROM_WE,
    output logic [15:0]     ROM_AD,
    output logic [7:0]      ROM_DT,
    output logic            CORE_RST,
    output logic            DL_DONE,
    output logic            DL_ERR
`ifdef DRUAGA_ROM_CSUM_EN
    ,
    output logic [7:0]      CSUM
`endif
);

    localparam int unsigned   HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);

    state_e          state_q, state_d;
    logic [19:0]     cnt_q, cnt_d, cnt_inc, cnt_post;
    logic [HW-1:0]   hold_q, hold_d;
    logic            err_q, err_d, err_post;
    logic            done_q, done_d;
    logic [NREG-1:0] we_q, we_d;
    logic [15:0]     ad_q, ad_d;
    logic [7:0]      dt_q, dt_d;

    logic [NREG-1:0] hit;
    logic [15:0]     off [NREG];
    logic [15:0]     off_sel;
    logic            in_load, wr_hit, wr_miss, load_entry, end_ok;

    for (genvar k = 0; k < NREG; k++) begin : g_dec
        druaga_rom_decode #(
            .BASE (REGION[k].base),
            .SIZE (REGION[k].size)
        ) u_dec (
            .addr_i (DL_ADDR),
            .hit_o  (hit[k]),
            .off_o  (off[k])
        );
    end

    // The regions do not overlap, so at most one offset survives the OR.
    always_comb begin
        off_sel = '0;
        for (int k = 0; k < NREG; k++) begin
            if (hit[k]) off_sel = off_sel | off[k];
        end
    end

    assign in_load  = (state_q == ST_LOAD);
    assign wr_hit   = in_load && DL_WR && (|hit);
    assign wr_miss  = in_load && DL_WR && !(|hit);
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 20'd1;
    assign cnt_post = wr_hit ? cnt_inc : cnt_q;
    assign err_post = err_q | wr_miss;

`ifdef DRUAGA_ROM_CSUM_EN
    logic [7:0] sum_q, sum_d, sum_post;

    assign sum_post = wr_hit ? sum_q + DL_DATA : sum_q;
    // The write that lands on the DL_ACT fall is part of the end check.
    assign end_ok   = (cnt_post == TOTAL_BYTES) && !err_post && (sum_post == CSUM_EXP);
    assign CSUM     = sum_q;

    always_comb begin
        sum_d = sum_q;
        if (load_entry)   sum_d = '0;
        else if (in_load) sum_d = sum_post;
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) sum_q <= '0;
        else          sum_q <= sum_d;
    end
`else
    // The write that lands on the DL_ACT fall is part of the end check.
    assign end_ok   = (cnt_post == TOTAL_BYTES) && !err_post;
`endif

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (DL_ACT) state_d = ST_LOAD;
            ST_LOAD:   if (!DL_ACT) state_d = end_ok ? ST_SETTLE : ST_HALT;
            ST_SETTLE: begin
                if (DL_ACT)              state_d = ST_LOAD;
                else if (hold_q == '0)   state_d = ST_RUN;
            end
            ST_RUN:    if (DL_ACT) state_d = ST_LOAD;
            ST_HALT:   if (DL_ACT) state_d = ST_LOAD;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        CORE_RST = 1'b1;
        DL_ERR   = err_q;
        case (state_q)
            ST_RUN:  CORE_RST = 1'b0;
            ST_HALT: DL_ERR   = 1'b1;
            default: ;
        endcase
        DL_DONE = done_q;
        ROM_WE  = we_q;
        ROM_AD  = ad_q;
        ROM_DT  = dt_q;
    end

    assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);

    always_comb begin
        cnt_d  = cnt_q;
        err_d  = err_q;
        done_d = done_q;
        hold_d = hold_q;
        we_d   = '0;
        ad_d   = ad_q;
        dt_d   = dt_q;

        if (load_entry) begin
            cnt_d  = '0;
            err_d  = 1'b0;
            done_d = 1'b0;
        end else if (in_load) begin
            cnt_d = cnt_post;
            err_d = err_post;
        end

        if (state_q == ST_SETTLE && state_d == ST_RUN) done_d = 1'b1;

        // Down-counter: loaded with RST_HOLD-1 on entry, so SETTLE lasts RST_HOLD cycles.
        if (state_d == ST_SETTLE && state_q != ST_SETTLE) begin
            hold_d = HOLD_INIT;
        end else if (state_q == ST_SETTLE && hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        if (wr_hit) begin
            we_d = hit;
            ad_d = off_sel;
            dt_d = DL_DATA;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q  <= '0;
            hold_q <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            we_q   <= '0;
            ad_q   <= '0;
            dt_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            err_q  <= err_d;
            done_q <= done_d;
            we_q   <= we_d;
            ad_q   <= ad_d;
            dt_q   <= dt_d;
        end
    end

endmodule

// File: tb/tb_druaga_rom_loader.sv
module tb_druaga_rom_loader;
    import druaga_rom_pkg::CSUM_EXP;

    localparam int RST_HOLD = 256;
    localparam int TOT      = 300;

    logic        MCLK    = 1'b0;
    logic        RESET_N = 1'b0;
    logic        DL_ACT  = 1'b0;
    logic        DL_WR   = 1'b0;
    logic [24:0] DL_ADDR = '0;
    logic [7:0]  DL_DATA = '0;
    logic [3:0]  ROM_WE;
    logic [15:0] ROM_AD;
    logic [7:0]  ROM_DT;
    logic        CORE_RST, DL_DONE, DL_ERR;
`ifdef DRUAGA_ROM_CSUM_EN
    logic [7:0]  CSUM;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 MCLK = ~MCLK;

    druaga_rom_loader #(
        .NREG        (4),
        .RST_HOLD    (RST_HOLD),
        .TOTAL_BYTES (20'(TOT))
    ) dut (
        .MCLK     (MCLK),
        .RESET_N  (RESET_N),
        .DL_ACT   (DL_ACT),
        .DL_WR    (DL_WR),
        .DL_ADDR  (DL_ADDR),
        .DL_DATA  (DL_DATA),
        .ROM_WE   (ROM_WE),
        .ROM_AD   (ROM_AD),
        .ROM_DT   (ROM_DT),
        .CORE_RST (CORE_RST),
        .DL_DONE  (DL_DONE),
        .DL_ERR   (DL_ERR)
`ifdef DRUAGA_ROM_CSUM_EN
        ,
        .CSUM     (CSUM)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Region map written from the memory layout: main 32K, sub 8K, chr 4K, obj 32K.
    function automatic int region_of(input logic [24:0] a);
        if (a < 25'h08000) return 0;
        if (a < 25'h0A000) return 1;
        if (a < 25'h0B000) return 2;
        if (a < 25'h13000) return 3;
        return -1;
    endfunction

    function automatic int base_of(input int r);
        case (r)
            0:       return 'h00000;
            1:       return 'h08000;
            2:       return 'h0A000;
            default: return 'h0B000;
        endcase
    endfunction

    // Reference model: download/settle bookkeeping at the transaction level.
    bit          m_load = 0, m_run = 0, m_halt = 0, m_err = 0, m_done = 0;
    int          m_cnt = 0, m_hold = 0;
    logic [7:0]  m_sum = '0;
    logic [3:0]  x_we = '0;
    logic [15:0] x_ad = '0;
    logic [7:0]  x_dt = '0;

    function automatic bit sum_ok(input logic [7:0] s);
`ifdef DRUAGA_ROM_CSUM_EN
        return s == CSUM_EXP;
`else
        return 1'b1 || (s == 8'h00);
`endif
    endfunction

    always @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_load = 0; m_run = 0; m_halt = 0; m_err = 0; m_done = 0;
            m_cnt = 0; m_hold = 0; m_sum = '0;
            x_we = '0; x_ad = '0; x_dt = '0;
        end else begin
            x_we = '0;
            if (m_load) begin
                if (DL_WR) begin
                    int r;
                    r = region_of(DL_ADDR);
                    if (r >= 0) begin
                        x_we  = 4'(1 << r);
                        x_ad  = 16'(int'(DL_ADDR) - base_of(r));
                        x_dt  = DL_DATA;
                        if (m_cnt < 'hFFFFF) m_cnt++;
                        m_sum = m_sum + DL_DATA;
                    end else begin
                        m_err = 1;
                    end
                end
                if (!DL_ACT) begin
                    m_load = 0;
                    if (m_cnt == TOT && !m_err && sum_ok(m_sum)) m_hold = RST_HOLD;
                    else m_halt = 1;
                end
            end else if (DL_ACT) begin
                m_load = 1; m_cnt = 0; m_err = 0; m_done = 0; m_sum = '0;
                m_hold = 0; m_run = 0; m_halt = 0;
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) begin
                    m_run  = 1;
                    m_done = 1;
                end
            end
        end
    end

    always @(negedge MCLK) begin
        chk("rom_we",   ROM_WE,   x_we);
        chk("rom_ad",   ROM_AD,   x_ad);
        chk("rom_dt",   ROM_DT,   x_dt);
        chk("core_rst", CORE_RST, !m_run);
        chk("dl_done",  DL_DONE,  m_done);
        chk("dl_err",   DL_ERR,   m_err | m_halt);
`ifdef DRUAGA_ROM_CSUM_EN
        chk("csum",     CSUM,     m_sum);
`endif
    end

    logic [24:0] fixed_addr [9] = '{25'h00000, 25'h07FFF, 25'h08000, 25'h08001, 25'h09FFF,
                                    25'h0A000, 25'h0AFFF, 25'h0B000, 25'h12FFF};

    // Returns at the falling edge just after the DL_ACT fall was sampled.
    task automatic download(input int nbytes, input bit coincide, input bit add_miss, input bit corrupt);
        logic [7:0]  sum;
        logic [7:0]  d;
        logic [24:0] a;
        sum = '0;
        @(negedge MCLK);
        DL_ACT = 1'b1;
        DL_WR  = 1'b0;
        @(negedge MCLK);
        chk("entry_err_clear",  DL_ERR,   0);
        chk("entry_done_clear", DL_DONE,  0);
        chk("entry_core_rst",   CORE_RST, 1);
        for (int i = 0; i < nbytes; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                DL_WR = 1'b0;
                @(negedge MCLK);
            end
            if (add_miss && i == nbytes / 2) begin
                DL_WR   = 1'b1;
                DL_ADDR = 25'h13000;
                DL_DATA = 8'($urandom);
                @(negedge MCLK);
                chk("miss_no_strobe", ROM_WE, 0);
                chk("miss_err",       DL_ERR, 1);
            end
            a = (i < 9) ? fixed_addr[i] : 25'($urandom_range(0, 32'h12FFF));
            d = (i == 3) ? 8'h5A : 8'($urandom);
            if (i == nbytes - 1) begin
                d = CSUM_EXP - sum;
                if (corrupt) d = d + 8'd1;
            end
            sum     = sum + d;
            DL_WR   = 1'b1;
            DL_ADDR = a;
            DL_DATA = d;
            if (coincide && i == nbytes - 1) DL_ACT = 1'b0;
            @(negedge MCLK);
            if (i == 3) begin
                chk("wr08001_we",       ROM_WE, 4'b0010);
                chk("wr08001_ad",       ROM_AD, 16'h0001);
                chk("wr08001_dt",       ROM_DT, 8'h5A);
                chk("model08001_we",    x_we,   4'b0010);
                chk("model08001_ad",    x_ad,   16'h0001);
            end
        end
        DL_WR = 1'b0;
        if (!coincide) begin
            DL_ACT = 1'b0;
            @(negedge MCLK);
        end
    endtask

    // Counts edges after the one that sampled the DL_ACT fall until CORE_RST drops.
    task automatic wait_run(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (n < RST_HOLD + 20 && !seen) begin
            @(posedge MCLK);
            n++;
            @(negedge MCLK);
            if (CORE_RST == 1'b0) seen = 1;
        end
        chk({name, "_released"}, seen, 1);
        chk({name, "_hold"},     n, RST_HOLD);
        chk({name, "_done"},     DL_DONE, 1);
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            DL_WR   = 1'($urandom_range(0, 1));
            DL_ADDR = 25'($urandom_range(0, 32'h12FFF));
            DL_DATA = 8'($urandom);
            @(negedge MCLK);
        end
        DL_WR = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        repeat (3) @(negedge MCLK);
        RESET_N = 1'b1;
        repeat (20) @(negedge MCLK);
        chk("idle_core_rst", CORE_RST, 1);
        chk("idle_we",       ROM_WE,   0);
        chk("idle_done",     DL_DONE,  0);
        chk("idle_err",      DL_ERR,   0);

        download(TOT, 0, 0, 0);
        wait_run("full");

        idle_noise(30);
        chk("run_core_rst", CORE_RST, 0);
        chk("run_done",     DL_DONE,  1);

        download(TOT - 1, 0, 0, 0);
        repeat (20) @(negedge MCLK);
        chk("short_err",      DL_ERR,   1);
        chk("short_core_rst", CORE_RST, 1);
        chk("short_done",     DL_DONE,  0);

        download(TOT, 0, 1, 0);
        repeat (20) @(negedge MCLK);
        chk("oor_err",      DL_ERR,   1);
        chk("oor_core_rst", CORE_RST, 1);

        download(TOT, 1, 0, 0);
        wait_run("coincide");

        download(TOT, 0, 0, 0);
        repeat (50) @(negedge MCLK);
        chk("settle_core_rst", CORE_RST, 1);
        chk("settle_done",     DL_DONE,  0);
        download(TOT, 0, 0, 0);
        wait_run("resettle");

`ifdef DRUAGA_ROM_CSUM_EN
        download(TOT, 0, 0, 1);
        repeat (20) @(negedge MCLK);
        chk("csum_bad_err",      DL_ERR,   1);
        chk("csum_bad_core_rst", CORE_RST, 1);
`endif

        @(negedge MCLK);
        DL_ACT = 1'b1;
        @(negedge MCLK);
        for (int i = 0; i < 100; i++) begin
            DL_WR   = 1'b1;
            DL_ADDR = 25'($urandom_range(0, 32'h12FFF));
            DL_DATA = 8'($urandom);
            @(negedge MCLK);
        end
        DL_WR   = 1'b1;
        DL_ADDR = 25'h08001;
        DL_DATA = 8'h77;
        @(posedge MCLK);
        #1;
        chk("pre_reset_strobe", ROM_WE, 4'b0010);
        RESET_N = 1'b0;
        #1;
        chk("arst_we",       ROM_WE,   0);
        chk("arst_ad",       ROM_AD,   0);
        chk("arst_dt",       ROM_DT,   0);
        chk("arst_core_rst", CORE_RST, 1);
        chk("arst_done",     DL_DONE,  0);
        chk("arst_err",      DL_ERR,   0);
        idle_noise(3);
        DL_ACT  = 1'b0;
        RESET_N = 1'b1;
        idle_noise(20);
        chk("post_reset_we",       ROM_WE,   0);
        chk("post_reset_core_rst", CORE_RST, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/druaga_rom_loader.md
Name: druaga_rom_loader

Overview:
- Sequences the HPS ROM download stream into the game core's per-region ROM write ports.
- Decodes the linear download address into one of NREG region write strobes and counts accepted bytes.
- Holds the game core in reset during download and for a fixed settle time afterwards.
- Reports completeness or error. It sits between hps_io and fpga_druaga on the MCLK domain.

Parameters:
- NREG, 4, number of ROM regions; region base/size table comes from the package.
- RST_HOLD, 256, MCLK cycles of core reset kept after download ends (must be >= 1).
- TOTAL_BYTES, 20'h13000, byte count that a complete download must reach.

Ports:
- MCLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- DL_ACT  in  1  download in progress (level).
- DL_WR  in  1  one-cycle byte write strobe.
- DL_ADDR  in  25  linear download byte address.
- DL_DATA  in  8  download byte.
- ROM_WE  out  NREG  one-hot region write strobe.
- ROM_AD  out  16  region-relative address.
- ROM_DT  out  8  byte to write.
- CORE_RST  out  1  active-high reset to the game core.
- DL_DONE  out  1  download completed with full count.
- DL_ERR  out  1  short download or out-of-range write seen.

Behaviour:
- Clock and reset: one clock, MCLK. Reset is asynchronous, active-low (RESET_N).
- Reset values: ROM_WE=0, ROM_AD=0, ROM_DT=0, CORE_RST=1, DL_DONE=0, DL_ERR=0. Byte count=0, hold counter=0, state=IDLE.
- States:
  - IDLE (after reset): CORE_RST=1. DL_ACT=1 goes to LOAD.
  - LOAD: CORE_RST=1.
  - SETTLE: CORE_RST=1. Hold counter counts RST_HOLD cycles.
  - RUN: CORE_RST=0.
  - HALT: CORE_RST=1, DL_ERR=1.
- IDLE -> LOAD when DL_ACT=1. On entry, clear byte count, DL_DONE and DL_ERR.
- LOAD write path: each DL_WR=1 is decoded against the region table (base <= addr < base+size).
  - Hit on region k: the next cycle gives ROM_WE[k]=1 for exactly one cycle, ROM_AD=addr-base[k] (low 16 bits), ROM_DT=DL_DATA, and the byte count increments. Write latency is 1 cycle.
  - Miss: no strobe, DL_ERR latched to 1, no count increment.
- LOAD -> SETTLE on DL_ACT falling.
  - A DL_WR in the same cycle as the fall is still accepted.
  - The count check uses the post-increment value.
  - If count == TOTAL_BYTES and no out-of-range write occurred, go to SETTLE. Otherwise go to HALT.
- SETTLE -> RUN after RST_HOLD cycles, asserting DL_DONE=1 (sticky until the next LOAD entry).
- DL_ACT=1 in SETTLE, RUN or HALT returns to LOAD: count cleared, CORE_RST=1 on the next cycle.
- HALT is exited only by a new DL_ACT or by RESET_N.
- Byte count is 20 bits and saturates at all-ones (no wrap). Overflow beyond TOTAL_BYTES in LOAD counts as an error at the end check.
- DL_WR outside LOAD is ignored: no strobe, no count.
- RESET_N asserted mid-LOAD aborts immediately to IDLE. Any pending strobe is dropped.

Optional Feature:
- Macro: DRUAGA_ROM_CSUM_EN.
- Enabled: an 8-bit additive sum of every accepted byte, cleared on LOAD entry. The end check also requires sum == CSUM_EXP (package constant). A mismatch goes to HALT. The sum is exposed on extra output port CSUM[7:0] (reset 0).
- Disabled: no CSUM port and no sum logic. The end check uses count and range only.

Decomposition:
- Package druaga_rom_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, RUN, HALT);
  - region typedef {base[24:0], size[16:0]};
  - the REGION table constant (main 0x00000/0x8000, sub 0x08000/0x2000, chr 0x0A000/0x1000, obj 0x0B000/0x8000);
  - CSUM_EXP.
- One sub-module, druaga_rom_decode: combinational address-to-region decode giving hit, one-hot index and offset, reused per NREG.

Test Plan:
- Reset: RESET_N=0, then release with DL_ACT=0 -> CORE_RST=1, ROM_WE=0, DL_DONE=0, state IDLE indefinitely.
- Full download: 0x13000 sequential writes, then DL_ACT falls.
  - Write to addr 0x08001 data 0x5A -> next cycle ROM_WE=4'b0010, ROM_AD=0x0001, ROM_DT=0x5A.
  - CORE_RST falls exactly RST_HOLD cycles after the DL_ACT fall; DL_DONE=1.
- Short download: 0x12FFF bytes -> HALT, DL_ERR=1, CORE_RST stays 1. A new DL_ACT clears DL_ERR.
- Out-of-range write: addr 0x13000 inside an otherwise full download -> no ROM_WE, DL_ERR=1, HALT at end.
- Edge events:
  - Final DL_WR coincident with the DL_ACT fall -> byte strobed and counted, SETTLE entered.
  - DL_ACT re-asserted during SETTLE -> back to LOAD, count restarts at 0.
- Async reset mid-LOAD after 100 bytes -> outputs at reset values asynchronously, no further ROM_WE.
- With DRUAGA_ROM_CSUM_EN: corrupt one byte -> CSUM differs from CSUM_EXP -> HALT, DL_ERR=1.
